// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage registers: state encoding,
// boundary payload widths, bubble constant and EX/MEM field offsets.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_state_e;

   localparam int unsigned IF_ID_W  = 64;
   localparam int unsigned ID_EX_W  = 180;
   localparam int unsigned EX_MEM_W = 142;
   localparam int unsigned MEM_WB_W = 72;

   localparam logic [0:EX_MEM_W-1] EX_MEM_BUBBLE = '0;

   // EX/MEM payload layout, bit 0 = MSB; offsets are the first bit of each field.
   localparam int unsigned NEXT_PC_OFF    = 0;
   localparam int unsigned NEXT_PC_W      = 32;
   localparam int unsigned OP_B_OFF       = 32;
   localparam int unsigned OP_B_W         = 32;
   localparam int unsigned DEST_REG_OFF   = 64;
   localparam int unsigned DEST_REG_W     = 5;
   localparam int unsigned ALU_RESULT_OFF = 69;
   localparam int unsigned ALU_RESULT_W   = 32;
   localparam int unsigned CTRL_OFF       = 101;
   localparam int unsigned CTRL_W         = 8;
   localparam int unsigned LEAP_ADDR_OFF  = 109;
   localparam int unsigned LEAP_ADDR_W    = 32;
   localparam int unsigned LEAP_OFF       = 141;
   localparam int unsigned LEAP_W         = 1;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module pipe_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_elastic_reg.sv
// Elastic pipeline stage register: valid/ready handshake, 2-entry skid, sync flush.
// Optional saturating stall/flush counters when PIPE_ELASTIC_PERF_EN is defined.
module pipe_elastic_reg
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH  = EX_MEM_W,
   parameter logic [0:WIDTH-1] BUBBLE = {WIDTH{1'b0}},
   parameter int unsigned      CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [0:WIDTH-1] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [0:WIDTH-1] out_data
`ifdef PIPE_ELASTIC_PERF_EN
   ,
   output logic [0:CNT_W-1] stall_cnt,
   output logic [0:CNT_W-1] flush_cnt
`endif
);

   if ((WIDTH == 0) || (CNT_W == 0)) begin : g_bad_param
      $error("pipe_elastic_reg: WIDTH and CNT_W must be non-zero");
   end

   pipe_state_e      state_q, state_d;
   logic [0:WIDTH-1] main_q, main_d;
   logic [0:WIDTH-1] skid_q, skid_d;
   logic             in_ready_q, in_ready_d;
   logic             accept, issue;

   assign accept = in_valid & in_ready_q;
   assign issue  = (state_q != EMPTY) & out_ready;

   // Vacated entries are rewritten with BUBBLE so out_data never shows stale payload.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         main_d  = BUBBLE;
         skid_d  = BUBBLE;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = ONE;
                  main_d  = in_data;
               end
            end
            ONE: begin
               if (accept && issue) begin
                  main_d = in_data;
               end else if (accept) begin
                  state_d = TWO;
                  skid_d  = in_data;
               end else if (issue) begin
                  state_d = EMPTY;
                  main_d  = BUBBLE;
               end
            end
            TWO: begin
               if (issue) begin
                  state_d = ONE;
                  main_d  = skid_q;
                  skid_d  = BUBBLE;
               end
            end
            default: begin
               state_d = EMPTY;
               main_d  = BUBBLE;
               skid_d  = BUBBLE;
            end
         endcase
      end
      in_ready_d = (state_d != TWO);
   end

   // NOTE: payload registers are reset too, since out_data must read BUBBLE straight out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= EMPTY;
         main_q     <= BUBBLE;
         skid_q     <= BUBBLE;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;

`ifdef PIPE_ELASTIC_PERF_EN
   pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc_i (out_valid & ~out_ready),
      .cnt_o (stall_cnt)
   );

   pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc_i (flush & (state_q != EMPTY)),
      .cnt_o (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Self-checking bench for pipe_elastic_reg: directed scenarios plus randomized
// traffic compared every cycle against a queue-based reference model.
module tb_pipe_elastic_reg;

   localparam int unsigned W     = 142;
   localparam int unsigned CNT_W = 4;
   localparam logic [0:W-1] BUB  = '0;

   logic         clk;
   logic         reset;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [0:W-1] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [0:W-1] out_data;
`ifdef PIPE_ELASTIC_PERF_EN
   logic [0:CNT_W-1] stall_cnt;
   logic [0:CNT_W-1] flush_cnt;
   localparam int CMAX = (1 << CNT_W) - 1;
   int m_stall;
   int m_flush;
`endif

   int n_cmp = 0;
   int n_err = 0;

   pipe_elastic_reg #(.WIDTH(W), .BUBBLE(BUB), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef PIPE_ELASTIC_PERF_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [0:W-1] rand_payload();
      logic [159:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return r[W-1:0];
   endfunction

   // Reference model: a FIFO of at most two payloads, head is what is presented.
   logic [0:W-1] mq[$];
   bit           model_valid = 0;

   always @(posedge clk) begin
      int sz;
      sz = mq.size();
      if (reset) begin
         mq.delete();
`ifdef PIPE_ELASTIC_PERF_EN
         m_stall = 0;
         m_flush = 0;
`endif
      end else begin
`ifdef PIPE_ELASTIC_PERF_EN
         if (sz > 0 && !out_ready && m_stall < CMAX) m_stall++;
         if (flush && sz > 0 && m_flush < CMAX) m_flush++;
`endif
         if (flush) begin
            mq.delete();
         end else begin
            if (sz > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && sz < 2) mq.push_back(in_data);
         end
      end
      model_valid = 1;
   end

   always @(negedge clk) begin
      if (model_valid) begin
         check("m_out_valid", 256'(out_valid), 256'(mq.size() > 0));
         check("m_in_ready", 256'(in_ready), 256'(mq.size() < 2));
         check("m_out_data", 256'(out_data), 256'((mq.size() > 0) ? mq[0] : BUB));
`ifdef PIPE_ELASTIC_PERF_EN
         check("m_stall_cnt", 256'(stall_cnt), 256'(m_stall));
         check("m_flush_cnt", 256'(flush_cnt), 256'(m_flush));
`endif
      end
   end

   task automatic step(input logic v, input logic [0:W-1] d, input logic rdy, input logic fl);
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
      flush     = fl;
      @(negedge clk);
   endtask

   initial begin
      logic [159:0] t;
      logic [0:W-1] db, a, b, c, d, e;
      int           thr;
      t  = {5{32'hDEADBEEF}};
      db = t[W-1:0];
      a  = rand_payload();
      b  = rand_payload();
      c  = rand_payload();
      d  = rand_payload();
      e  = rand_payload();

      // Reset held two cycles with a valid offer: nothing is captured.
      reset     = 1'b1;
      in_valid  = 1'b1;
      in_data   = db;
      out_ready = 1'b0;
      flush     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      step(1'b0, db, 1'b0, 1'b0);
      check("rst_out_valid", 256'(out_valid), 256'(1'b0));
      check("rst_in_ready", 256'(in_ready), 256'(1'b1));
      check("rst_out_data", 256'(out_data), 256'(BUB));

      // Streaming with out_ready high.
      step(1'b1, a, 1'b1, 1'b0);
      check("stream_a", 256'(out_data), 256'(a));
      check("stream_rdy", 256'(in_ready), 256'(1'b1));
      step(1'b1, b, 1'b1, 1'b0);
      check("stream_b", 256'(out_data), 256'(b));
      step(1'b1, c, 1'b1, 1'b0);
      check("stream_c", 256'(out_data), 256'(c));
      step(1'b0, db, 1'b1, 1'b0);
      check("stream_drain_v", 256'(out_valid), 256'(1'b0));
      check("stream_drain_d", 256'(out_data), 256'(BUB));

      // Backpressure: fill both entries, C ignored, then release in order.
      step(1'b1, a, 1'b0, 1'b0);
      step(1'b1, b, 1'b0, 1'b0);
      check("bp_in_ready", 256'(in_ready), 256'(1'b0));
      check("bp_head_a", 256'(out_data), 256'(a));
      step(1'b1, c, 1'b0, 1'b0);
      check("bp_hold_a", 256'(out_data), 256'(a));
      step(1'b1, c, 1'b1, 1'b0);
      check("bp_then_b", 256'(out_data), 256'(b));
      step(1'b1, c, 1'b1, 1'b0);
      check("bp_then_c", 256'(out_data), 256'(c));
      step(1'b0, db, 1'b1, 1'b0);
      check("bp_empty", 256'(out_valid), 256'(1'b0));

      // Flush while full with a simultaneous offer of D.
      step(1'b1, a, 1'b0, 1'b0);
      step(1'b1, b, 1'b0, 1'b0);
      step(1'b1, d, 1'b0, 1'b1);
      check("fl_out_valid", 256'(out_valid), 256'(1'b0));
      check("fl_out_data", 256'(out_data), 256'(BUB));
      check("fl_in_ready", 256'(in_ready), 256'(1'b1));
`ifdef PIPE_ELASTIC_PERF_EN
      check("fl_cnt_one", 256'(flush_cnt), 256'(1));
`endif
      step(1'b0, db, 1'b1, 1'b0);
      check("fl_d_dropped", 256'(out_valid), 256'(1'b0));

      // Flush while empty is a no-op.
      step(1'b0, db, 1'b0, 1'b1);
      check("fle_out_valid", 256'(out_valid), 256'(1'b0));
      check("fle_in_ready", 256'(in_ready), 256'(1'b1));
`ifdef PIPE_ELASTIC_PERF_EN
      check("fle_cnt_same", 256'(flush_cnt), 256'(1));
`endif

      // Long stall: counter saturates, reset clears it.
      step(1'b1, e, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b0, db, 1'b0, 1'b0);
      check("stall_head_e", 256'(out_data), 256'(e));
`ifdef PIPE_ELASTIC_PERF_EN
      check("stall_sat", 256'(stall_cnt), 256'(15));
`endif
      reset = 1'b1;
      step(1'b0, db, 1'b0, 1'b0);
      reset = 1'b0;
      check("rst2_out_valid", 256'(out_valid), 256'(1'b0));
`ifdef PIPE_ELASTIC_PERF_EN
      check("rst2_stall_zero", 256'(stall_cnt), 256'(0));
`endif

      // Randomized traffic with drifting backpressure, rare flushes and resets.
      for (int i = 0; i < 3000; i++) begin
         thr   = 1 + ((i / 200) % 3);
         reset = ($urandom_range(0, 499) == 0);
         step($urandom_range(0, 3) != 0, rand_payload(),
              $urandom_range(0, 3) < thr, $urandom_range(0, 29) == 0);
      end
      reset = 1'b0;
      step(1'b0, db, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
